instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the CPU's control decode: packs op/funct3/funct7b5/rd/rs1/rs2/imm fields into 32-bit RV32I words.
//  Each accepted word is buffered in a FIFO and written sequentially into instruction memory through a valid/ready port.
//  Serves as the program loader in front of imem for the single-cycle CPU and its testbenches.
// PARAMETERS
//  ADDR_W     8  imem word-address width; write address wraps at 2**ADDR_W
//  FIFO_DEPTH 4  encoded-word FIFO entries (power of 2, >=2)
//  BASE_ADDR  0  word address of first write after reset/clear
// PORTS
//  clk        in  1      clock, rising edge
//  reset_n    in  1      asynchronous, active-low reset
//  clear      in  1      sync restart: flush FIFO, addr=BASE_ADDR, clear flags, state RUN
//  in_valid   in  1      field bundle valid
//  in_ready   out 1      bundle accepted when in_valid&in_ready
//  in_last    in  1      marks final instruction of program
//  in_fmt     in  3      000 I, 001 S, 010 B, 011 J, 100 U, 101 R, 11x illegal
//  in_op      in  7      opcode [6:0]
//  in_funct3  in  3      funct3
//  in_funct7b5 in 1      funct7 bit5 (R-type, I-type shifts)
//  in_rd/in_rs1/in_rs2 in 5 each  register indices
//  in_imm     in  32     immediate as signed byte offset/value (U: full 32-bit value)
//  wr_valid   out 1      imem write request
//  wr_ready   in  1      imem accepts write when wr_valid&wr_ready
//  wr_addr    out ADDR_W word address of current write
//  wr_data    out 32     encoded instruction (FIFO head)
//  wr_count   out ADDR_W+1 words written since reset/clear (saturates at all-ones)
//  done       out 1      high in DONE
//  err_fmt    out 1      sticky: illegal in_fmt seen
//  err_range  out 1      sticky: immediate range/alignment violation seen
//  wrapped    out 1      sticky: wr_addr wrapped past 2**ADDR_W-1
// BEHAVIOUR
//  Reset: FIFO empty; state RUN; wr_addr=BASE_ADDR; wr_valid, wr_count, done and all error flags 0; in_ready=1.
//  Encode (combinational into FIFO write): R {0,f7b5,5'b0,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op},
//   except op=0010011 with f3=001/101 -> {0,f7b5,imm[9:5]=0,imm[4:0],...}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op};
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//  Latency: bundle accepted in cycle N with FIFO empty -> wr_valid=1 with its word in cycle N+1.
//  Handshake: in_ready = (state==RUN) & ~full; a pop in the same cycle does not free a slot for that cycle's push.
//   wr_valid = ~empty; wr_addr/wr_data hold until wr_ready; wr_valid drops without wr_ready only on clear.
//  On each write beat: pop; wr_addr+1 mod 2**ADDR_W (set wrapped on 2**ADDR_W-1 -> 0); wr_count+1.
//  Illegal fmt: bundle accepted, nothing pushed, err_fmt=1; in_last still honoured.
//  FSM: RUN --accept with in_last--> DRAIN (in_ready=0) --FIFO empty--> DONE (done=1, in_ready=0) --clear--> RUN.
//  clear wins over every other event in the same cycle, in any state; the next cycle shows wr_valid=0.
//  reset_n low mid-write: immediate return to reset values; the pending word is discarded.
// CONFIGURATION
//  ENC_RANGE_CHECK_EN defined: I/S imm must fit signed 12 bits; B signed 13 bits with imm[0]=0;
//   J signed 21 bits with imm[0]=0; U imm[11:0]=0; I-shift imm[11:5]=0.
//   A violating bundle is accepted and dropped (no push, address unchanged), err_range=1, in_last honoured.
//  ENC_RANGE_CHECK_EN undefined: no checks; fields truncated as encoded; err_range ties to 0.
// TESTING
//  addi x1,x0,5 (I, op 0010011, f3 0, rd 1, imm 5), wr_ready=1 -> next cycle wr_data=0x00500093, wr_addr=0, wr_count=1.
//  beq x1,x2,-8 (B, op 1100011, rs1 1, rs2 2, imm -8) -> wr_data=0xFE208CE3; lui x5,0x12345000 (U) -> 0x123452B7.
//  wr_ready=0, 6 back-to-back bundles -> in_ready=0 after 4 accepted; wr_ready=1 -> words written in order to addrs 0..3.
//  addi imm=2048: with ENC_RANGE_CHECK_EN -> no write, err_range=1, wr_addr stays; without -> 0x80000093 written.
//  ADDR_W=2, 5 words -> 5th word at addr 0 with wrapped=1; in_last on 5th -> DRAIN, then done=1 once FIFO empty.
//  clear while wr_valid=1, wr_ready=0 -> next cycle wr_valid=0, wr_addr=0, wr_count=0, done=0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs RV32I instruction fields into 32-bit words.
// Encoded words pass through a small FIFO. They are then written sequentially
// into instruction memory over a valid/ready write port.
// Optional build macro: ENC_RANGE_CHECK_EN. When it is defined, bundles whose
// immediate does not fit the format are dropped and err_range is raised.
module instr_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   wr_count,
    output logic              done,
    output logic              err_fmt,
    output logic              err_range,
    output logic              wrapped
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_fmt_q, err_fmt_d, err_range_q, err_range_d;
    logic                wrapped_q, wrapped_d;
    logic [31:0]         mem_q [FIFO_DEPTH];

    logic        full, empty, accept, push, pop;
    logic        fmt_ok, range_bad, is_shift;
    logic [31:0] enc_word;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // Uses the registered full flag, so a pop in the same cycle does not free a slot for a push.
    assign in_ready = (state_q == ST_RUN) && !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && fmt_ok && !range_bad && !clear;
    assign pop      = !empty && wr_ready && !clear;
    assign is_shift = (in_op == 7'b0010011) && (in_funct3[1:0] == 2'b01);

    assign wr_valid  = !empty;
    assign wr_data   = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign wr_addr   = addr_q;
    assign wr_count  = count_q;
    assign done      = (state_q == ST_DONE);
    assign err_fmt   = err_fmt_q;
    assign err_range = err_range_q;
    assign wrapped   = wrapped_q;

    // Field packing for each instruction format.
    always_comb begin
        enc_word = 32'd0;
        fmt_ok   = 1'b1;
        case (in_fmt)
            3'b000: begin
                if (is_shift)
                    enc_word = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            end
            3'b001: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
            3'b010: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_op};
            3'b011: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
            3'b100: enc_word = {in_imm[31:12], in_rd, in_op};
            3'b101: enc_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic fits12, fits13, fits21;
    // Signed fit means every bit from the sign position up has the same value.
    assign fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

    // Immediate legality per format; a failing bundle is consumed but not pushed.
    always_comb begin
        range_bad = 1'b0;
        case (in_fmt)
            3'b000:  range_bad = is_shift ? (|in_imm[11:5]) : !fits12;
            3'b001:  range_bad = !fits12;
            3'b010:  range_bad = !fits13 || in_imm[0];
            3'b011:  range_bad = !fits21 || in_imm[0];
            3'b100:  range_bad = |in_imm[11:0];
            default: range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    // Next-state logic: FIFO pointers, write address/count, sticky flags and FSM.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        addr_d      = addr_q;
        count_d     = count_q;
        err_fmt_d   = err_fmt_q;
        err_range_d = err_range_q;
        wrapped_d   = wrapped_q;
        if (clear) begin
            state_d     = ST_RUN;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            addr_d      = BASE;
            count_d     = '0;
            err_fmt_d   = 1'b0;
            err_range_d = 1'b0;
            wrapped_d   = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                addr_d   = addr_q + 1'b1;
                if (&addr_q)
                    wrapped_d = 1'b1;
                if (!(&count_q))
                    count_d = count_q + 1'b1;
            end
            if (accept && !fmt_ok)
                err_fmt_d = 1'b1;
            if (accept && fmt_ok && range_bad)
                err_range_d = 1'b1;
            case (state_q)
                ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
                ST_DRAIN: if (empty) state_d = ST_DONE;
                default:  state_d = ST_DONE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= BASE;
            count_q     <= '0;
            err_fmt_q   <= 1'b0;
            err_range_q <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            err_fmt_q   <= err_fmt_d;
            err_range_q <= err_range_d;
            wrapped_q   <= wrapped_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers mark validity.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (ADDR_W=2 so wrap and count saturation are reachable).
module tb_instr_encoder_loader;

    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [2:0]  in_fmt = 3'd0;
    logic [6:0]  in_op = 7'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic        in_funct7b5 = 1'b0;
    logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [AW-1:0] wr_addr;
    logic [31:0] wr_data;
    logic [AW:0] wr_count;
    logic        done, err_fmt, err_range, wrapped;

    int checks = 0;
    int errors = 0;

    instr_encoder_loader #(.ADDR_W(AW), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_count(wr_count), .done(done), .err_fmt(err_fmt), .err_range(err_range),
        .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        drop;
    } vec_t;

    vec_t vecs[12];

`ifdef ENC_RANGE_CHECK_EN
    localparam logic RDROP = 1'b1;
`else
    localparam logic RDROP = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] fmt, input logic [6:0] op,
                                input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] word, input logic drop);
        vec_t v;
        v.name = n; v.fmt = fmt; v.op = op; v.f3 = f3; v.f7 = f7;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.word = word; v.drop = drop;
        return v;
    endfunction

    // Model state for the table walk.
    logic [AW-1:0] m_addr;
    logic [AW:0]   m_count;
    logic          m_wrapped, m_err_fmt, m_err_range;
    logic [31:0]   exp_q[$];
    int            accepted;

    initial begin
        vecs[0]  = mk("addi",      3'b000, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 1'b0);
        vecs[1]  = mk("beq",       3'b010, 7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8,      32'hFE208CE3, 1'b0);
        vecs[2]  = mk("lui",       3'b100, 7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
        vecs[3]  = mk("add",       3'b101, 7'b0110011, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 1'b0);
        vecs[4]  = mk("sub",       3'b101, 7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0);
        vecs[5]  = mk("sw",        3'b001, 7'b0100011, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12,       32'h0020A623, 1'b0);
        vecs[6]  = mk("jal8",      3'b011, 7'b1101111, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0);
        vecs[7]  = mk("jalm4",     3'b011, 7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd4,      32'hFFDFF06F, 1'b0);
        vecs[8]  = mk("slli",      3'b000, 7'b0010011, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd3,        32'h00309093, 1'b0);
        vecs[9]  = mk("srai_bad",  3'b000, 7'b0010011, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd35,       32'h4030D093, RDROP);
        vecs[10] = mk("addi_2048", 3'b000, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, RDROP);
        vecs[11] = mk("bad_fmt",   3'b110, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1,        32'h0,        1'b1);

        // Reset values while reset_n is held low.
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr",  wr_addr, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_done",     done, 0);
        chk("rst_flags",    {err_fmt, err_range, wrapped}, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Table walk: one bundle at a time with wr_ready=1.
        m_addr = '0; m_count = '0; m_wrapped = 1'b0; m_err_fmt = 1'b0; m_err_range = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].fmt, vecs[i].op, vecs[i].f3, vecs[i].f7,
                  vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (vecs[i].fmt[2:1] == 2'b11) m_err_fmt = 1'b1;
            else if (vecs[i].drop) m_err_range = 1'b1;
            if (!vecs[i].drop) begin
                chk({vecs[i].name, "_valid"}, wr_valid, 1);
                chk({vecs[i].name, "_data"}, wr_data, vecs[i].word);
                chk({vecs[i].name, "_addr"}, wr_addr, m_addr);
                if (m_addr == '1) m_wrapped = 1'b1;
                m_addr = m_addr + 1'b1;
                if (m_count != '1) m_count = m_count + 1'b1;
            end else begin
                chk({vecs[i].name, "_novalid"}, wr_valid, 0);
            end
            tick();
            chk({vecs[i].name, "_count"}, wr_count, m_count);
            chk({vecs[i].name, "_next_addr"}, wr_addr, m_addr);
            chk({vecs[i].name, "_flags"}, {err_fmt, err_range, wrapped},
                {m_err_fmt, m_err_range, m_wrapped});
        end

        // Clear restores the start state and clears sticky flags.
        do_clear();
        chk("clr_addr",  wr_addr, 0);
        chk("clr_count", wr_count, 0);
        chk("clr_flags", {err_fmt, err_range, wrapped}, 0);

        // Backpressure: 6 back-to-back bundles with wr_ready=0.
        wr_ready = 1'b0;
        accepted = 0;
        for (int k = 1; k <= 6; k++) begin
            drive(3'b000, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, k);
            in_valid = 1'b1;
            if (in_ready) begin
                accepted++;
                exp_q.push_back((32'(k) << 20) | 32'h93);
            end
            tick();
            if (k == 1) chk("bp_latency_valid", wr_valid, 1);
        end
        in_valid = 1'b0;
        chk("bp_accepted", accepted, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_data", wr_data, 32'h00100093);
        chk("bp_hold_addr", wr_addr, 0);
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_word", wr_data, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF);
            chk("bp_addr", wr_addr, i);
            tick();
        end
        chk("bp_empty",   wr_valid, 0);
        chk("bp_count",   wr_count, 4);
        chk("bp_wrapped", wrapped, 1);

        // Wrap with ADDR_W=2 and program end: 5 words, last one flagged.
        do_clear();
        for (int k = 0; k < 5; k++) begin
            drive(3'b000, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, k + 16);
            in_last = (k == 4);
            in_valid = 1'b1;
            tick();
            chk("wrap_data", wr_data, (32'(k + 16) << 20) | 32'h93);
            chk("wrap_addr", wr_addr, k % 4);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("wrap_flag",        wrapped, 1);
        chk("drain_in_ready",   in_ready, 0);
        chk("drain_not_done",   done, 0);
        for (int i = 0; i < 8 && !done; i++) tick();
        chk("done",             done, 1);
        chk("done_in_ready",    in_ready, 0);
        chk("done_count",       wr_count, 5);
        chk("done_empty",       wr_valid, 0);

        // Clear from DONE, then clear against a stalled write (with a bundle offered).
        do_clear();
        chk("clr_done_ready", in_ready, 1);
        chk("clr_done_done",  done, 0);
        wr_ready = 1'b0;
        drive(3'b100, 7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        in_valid = 1'b1;
        tick();
        chk("stall_valid", wr_valid, 1);
        chk("stall_data",  wr_data, 32'h123452B7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("stall_clr_valid", wr_valid, 0);
        chk("stall_clr_addr",  wr_addr, 0);
        chk("stall_clr_count", wr_count, 0);
        chk("stall_clr_done",  done, 0);
        chk("stall_clr_ready", in_ready, 1);

        // Asynchronous reset mid-write discards the pending word at once.
        drive(3'b000, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("arst_pre_valid", wr_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", wr_valid, 0);
        chk("arst_addr",  wr_addr, 0);
        chk("arst_ready", in_ready, 1);
        #3;
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
